uart_transmitter: RTL and testbench

UART_TRANSMITTER -- requirements
Module: uart_transmitter

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_transmitter_if.sv | 20 ++
 rtl/uart_transmitter.sv | 136 +++++++++++++
 tb/tb_uart_transmitter.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states and 8N1 frame constants.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_e;

    localparam int unsigned UART_DATA_BITS  = 8;
    localparam int unsigned UART_FRAME_BITS = 10;

endpackage

// File: rtl/uart_transmitter_if.sv
// Byte-input valid/ready handshake into the UART transmitter.
interface uart_transmitter_if;

    logic [7:0] data_in;
    logic       data_in_valid;
    logic       data_in_ready;

    modport master (
        output data_in,
        output data_in_valid,
        input  data_in_ready
    );

    modport slave (
        input  data_in,
        input  data_in_valid,
        output data_in_ready
    );

endinterface

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter with a one-byte holding register in front of the shift register,
// allowing one byte to wait while another is on the line.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ = 125_000_000,
    parameter int unsigned BAUD_RATE  = 115_200
) (
    input  logic                clk,
    input  logic                reset,
    uart_transmitter_if.slave   in_if,
    output logic                serial_out
);

    localparam int unsigned SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
    localparam int unsigned CNT_W  = (SYMBOL_EDGE_TIME > 1) ? $clog2(SYMBOL_EDGE_TIME) : 1;
    localparam int unsigned BIT_W  = $clog2(UART_DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYMBOL_EDGE_TIME - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(UART_DATA_BITS - 1);

    uart_state_e                state_q, state_d;
    logic [CNT_W-1:0]           baud_q, baud_d;
    logic [BIT_W-1:0]           bit_q, bit_d;
    logic [UART_DATA_BITS-1:0]  shift_q, shift_d;
    logic [UART_DATA_BITS-1:0]  hold_q, hold_d;
    logic                       hold_full_q, hold_full_d;
    logic                       serial_q, serial_d;

    logic accept;
    logic load;
    logic bit_end;

    assign in_if.data_in_ready = !hold_full_q && !reset;
    assign accept     = in_if.data_in_valid && in_if.data_in_ready;
    assign bit_end    = (baud_q == CNT_LAST);
    assign serial_out = serial_q;

    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        load        = 1'b0;

        unique case (state_q)
            IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                if (hold_full_q) begin
                    state_d = START;
                    load    = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (hold_full_q) begin
                        state_d = START;
                        load    = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // load needs a full holder and accept needs an empty one, so they never collide
        if (load) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
        end
        if (accept) begin
            hold_d      = in_if.data_in;
            hold_full_d = 1'b1;
        end
    end

    // Line is registered from the current state, so it trails the FSM by one cycle;
    // this yields the handshake+2 start-bit latency while keeping every bit full width.
    always_comb begin
        serial_d = 1'b1;
        unique case (state_q)
            START:   serial_d = 1'b0;
            DATA:    serial_d = shift_q[bit_q];
            default: serial_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            baud_q      <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            serial_q    <= 1'b1;
        end else begin
            state_q     <= state_d;
            baud_q      <= baud_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            serial_q    <= serial_d;
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: 10 cycles/bit instance plus a default-parameter instance.
module tb_uart_transmitter;
    import uart_pkg::*;

    logic clk;
    logic reset;
    logic serial_out;
    logic serial_out2;

    int total;
    int bad;

    uart_transmitter_if u_if ();
    uart_transmitter_if u_if2 ();

    uart_transmitter #(
        .CLOCK_FREQ (1000),
        .BAUD_RATE  (100)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .in_if      (u_if),
        .serial_out (serial_out)
    );

    uart_transmitter u_dut_def (
        .clk        (clk),
        .reset      (reset),
        .in_if      (u_if2),
        .serial_out (serial_out2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [9:0] frame_of(input logic [7:0] b);
        return {1'b1, b, 1'b0};
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        u_if.data_in_valid  = 1'b0;
        u_if.data_in        = 8'h00;
        u_if2.data_in_valid = 1'b0;
        u_if2.data_in       = 8'h00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (serial_out !== 1'b1) begin
                bad++;
                $display("FAIL reset_line cyc=%0d got=%b exp=1", i, serial_out);
            end
            total++;
            if (u_if.data_in_ready !== 1'b0) begin
                bad++;
                $display("FAIL reset_ready cyc=%0d got=%b exp=0", i, u_if.data_in_ready);
            end
        end
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (u_if.data_in_ready !== 1'b1) begin
            bad++;
            $display("FAIL post_reset_ready got=%b exp=1", u_if.data_in_ready);
        end
        total++;
        if (serial_out !== 1'b1) begin
            bad++;
            $display("FAIL post_reset_line got=%b exp=1", serial_out);
        end
    endtask

    task automatic test_single_byte();
        logic [9:0] fr;
        fr = frame_of(8'h55);
        @(negedge clk);
        u_if.data_in_valid = 1'b1;
        u_if.data_in       = 8'h55;
        total++;
        if (u_if.data_in_ready !== 1'b1) begin
            bad++;
            $display("FAIL single_ready_idle got=%b exp=1", u_if.data_in_ready);
        end
        @(negedge clk);
        u_if.data_in_valid = 1'b0;
        u_if.data_in       = 8'h00;
        total++;
        if (u_if.data_in_ready !== 1'b0) begin
            bad++;
            $display("FAIL single_ready_held got=%b exp=0", u_if.data_in_ready);
        end
        @(negedge clk);
        total++;
        if (serial_out !== 1'b1) begin
            bad++;
            $display("FAIL single_latency_hi got=%b exp=1", serial_out);
        end
        total++;
        if (u_if.data_in_ready !== 1'b1) begin
            bad++;
            $display("FAIL single_ready_after_load got=%b exp=1", u_if.data_in_ready);
        end
        for (int j = 0; j < 10; j++) begin
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                total++;
                if (serial_out !== fr[j]) begin
                    bad++;
                    $display("FAIL single_line bit=%0d cyc=%0d got=%b exp=%b", j, c, serial_out, fr[j]);
                end
            end
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total++;
            if (serial_out !== 1'b1) begin
                bad++;
                $display("FAIL single_idle cyc=%0d got=%b exp=1", c, serial_out);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [29:0] stream;
        logic        hs;
        logic        exp;
        stream = {frame_of(8'h7E), frame_of(8'h3C), frame_of(8'hA5)};
        hs = 1'b0;
        for (int k = 0; k < 320; k++) begin
            @(negedge clk);
            if (hs) u_if.data_in_valid = 1'b0;
            if (k == 0) begin
                u_if.data_in_valid = 1'b1;
                u_if.data_in       = 8'hA5;
            end
            if (k == 33) begin
                u_if.data_in_valid = 1'b1;
                u_if.data_in       = 8'h3C;
                total++;
                if (u_if.data_in_ready !== 1'b1) begin
                    bad++;
                    $display("FAIL b2b_second_ready got=%b exp=1", u_if.data_in_ready);
                end
            end
            if (k == 34) begin
                u_if.data_in_valid = 1'b1;
                u_if.data_in       = 8'h7E;
            end
            if (k == 34 || k == 60 || k == 90) begin
                total++;
                if (u_if.data_in_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL b2b_third_stall k=%0d got=%b exp=0", k, u_if.data_in_ready);
                end
            end
            hs = u_if.data_in_valid && u_if.data_in_ready;
            exp = (k >= 3 && k < 303) ? stream[(k - 3) / 10] : 1'b1;
            total++;
            if (serial_out !== exp) begin
                bad++;
                $display("FAIL b2b_line k=%0d got=%b exp=%b", k, serial_out, exp);
            end
        end
        total++;
        if (u_if.data_in_valid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_third_accepted valid_still=%b exp=0", u_if.data_in_valid);
        end
    endtask

    task automatic test_hold_toggle();
        logic [29:0] stream;
        logic        hs;
        logic        exp;
        int          p;
        logic [7:0]  tog;
        stream = {frame_of(8'hC3), frame_of(8'h3A), frame_of(8'h96)};
        hs = 1'b0;
        p  = 0;
        for (int k = 0; k < 320; k++) begin
            @(negedge clk);
            if (hs) p++;
            tog = 8'(k * 37) ^ 8'h5A;
            u_if.data_in_valid = (p < 3);
            case (p)
                0:       u_if.data_in = 8'h96;
                1:       u_if.data_in = 8'h3A;
                2:       u_if.data_in = u_if.data_in_ready ? 8'hC3 : tog;
                default: u_if.data_in = tog;
            endcase
            hs = u_if.data_in_valid && u_if.data_in_ready;
            exp = (k >= 3 && k < 303) ? stream[(k - 3) / 10] : 1'b1;
            total++;
            if (serial_out !== exp) begin
                bad++;
                $display("FAIL toggle_line k=%0d got=%b exp=%b", k, serial_out, exp);
            end
        end
        u_if.data_in_valid = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        logic hs;
        logic exp;
        hs = 1'b0;
        for (int k = 0; k < 260; k++) begin
            @(negedge clk);
            if (hs) u_if.data_in_valid = 1'b0;
            if (k == 0) begin
                u_if.data_in_valid = 1'b1;
                u_if.data_in       = 8'h00;
            end
            if (k == 2) begin
                u_if.data_in_valid = 1'b1;
                u_if.data_in       = 8'hFF;
            end
            if (k == 40) begin
                total++;
                if (u_if.data_in_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL rst_pending_ready got=%b exp=0", u_if.data_in_ready);
                end
            end
            if (k == 56) begin
                total++;
                if (u_if.data_in_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL rst_ready_during got=%b exp=0", u_if.data_in_ready);
                end
                reset = 1'b0;
            end
            if (k == 57) begin
                total++;
                if (u_if.data_in_ready !== 1'b1) begin
                    bad++;
                    $display("FAIL rst_ready_after got=%b exp=1", u_if.data_in_ready);
                end
            end
            hs = u_if.data_in_valid && u_if.data_in_ready;
            exp = (k >= 3 && k < 56) ? 1'b0 : 1'b1;
            total++;
            if (serial_out !== exp) begin
                bad++;
                $display("FAIL rst_line k=%0d got=%b exp=%b", k, serial_out, exp);
            end
            if (k == 55) reset = 1'b1;
        end
    endtask

    task automatic test_default_params();
        logic [7:0] bytes [3];
        logic [7:0] rx;
        int         t;
        bytes[0] = 8'h00;
        bytes[1] = 8'hFF;
        bytes[2] = 8'h5A;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            u_if2.data_in_valid = 1'b1;
            u_if2.data_in       = bytes[n];
            total++;
            if (u_if2.data_in_ready !== 1'b1) begin
                bad++;
                $display("FAIL def_ready byte=%0d got=%b exp=1", n, u_if2.data_in_ready);
            end
            @(negedge clk);
            u_if2.data_in_valid = 1'b0;
            t = 0;
            while (serial_out2 !== 1'b0 && t < 50) begin
                @(negedge clk);
                t++;
            end
            total++;
            if (t !== 2) begin
                bad++;
                $display("FAIL def_start_latency byte=%0d got=%0d exp=2", n, t);
            end
            repeat (542) @(negedge clk);
            total++;
            if (serial_out2 !== 1'b0) begin
                bad++;
                $display("FAIL def_start_mid byte=%0d got=%b exp=0", n, serial_out2);
            end
            rx = 8'h00;
            for (int i = 0; i < 8; i++) begin
                repeat (1085) @(negedge clk);
                rx[i] = serial_out2;
            end
            total++;
            if (rx !== bytes[n]) begin
                bad++;
                $display("FAIL def_data byte=%0d got=%h exp=%h", n, rx, bytes[n]);
            end
            repeat (1085) @(negedge clk);
            total++;
            if (serial_out2 !== 1'b1) begin
                bad++;
                $display("FAIL def_stop byte=%0d got=%b exp=1", n, serial_out2);
            end
            repeat (600) @(negedge clk);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_hold_toggle();
        test_reset_mid_frame();
        test_default_params();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
